// File: rtl/tqvp_stevej_wdt_escalator_if.sv
// TinyQV peripheral register bus as seen by the watchdog escalator.
// The CPU side is the master and the peripheral is the slave.
interface tqvp_stevej_wdt_escalator_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/tqvp_stevej_wdt_escalator.sv
// Watchdog expiry escalator: warning irq, software grace period, then a
// fixed-length system reset pulse, with a sticky saturating escalation count.
//
// state   | meaning
// IDLE    | armed, waiting for a rising edge on wdt_expired while enabled
// WARN    | irq high, grace countdown running, ACK returns to IDLE
// RESET   | sys_reset_out high for max(RST_LEN,1) cycles, cannot be cut short
// HOLDOFF | waiting for wdt_expired to go low before re-arming
module tqvp_stevej_wdt_escalator #(
  parameter logic [15:0] GRACE_RST  = 16'd1000,
  parameter logic [7:0]  RSTLEN_RST = 8'd16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wdt_expired,
  tqvp_stevej_wdt_escalator_if.slave         bus,
  output logic                               irq,
  output logic                               sys_reset_out,
  output logic [1:0]                         state_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARN    = 2'd1,
    ST_RESET   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic        enable;
  logic [15:0] grace;
  logic [7:0]  rst_len;
  logic [7:0]  reset_count;
  logic        wdt_prev;
  logic        count_inc;

  logic        wr, wr_ctrl, wr_grace, wr_rst_len, wr_status, ack, rise;
  logic [7:0]  rst_len_m1;

  assign wr         = (bus.data_write_n != 2'b11);
  assign wr_ctrl    = wr && (bus.address == 6'h0);
  assign wr_grace   = wr && (bus.address == 6'h2);
  assign wr_rst_len = wr && (bus.address == 6'h3);
  assign wr_status  = wr && (bus.address == 6'h4);
  assign ack        = wr && (bus.address == 6'h1) && (bus.data_in[7:0] == 8'hA5);
  assign rise       = wdt_expired & ~wdt_prev;
  // A zero length still produces a one-cycle pulse.
  assign rst_len_m1 = (rst_len == 8'd0) ? 8'd0 : rst_len - 8'd1;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    count_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && rise) begin
          state_next = ST_WARN;
          cnt_next   = grace;
        end
      end
      ST_WARN: begin
        if (ack) begin
          state_next = ST_IDLE;
        end else if (!enable) begin
          state_next = ST_IDLE;
        end else if (cnt == 16'd0) begin
          state_next = ST_RESET;
          cnt_next   = {8'h00, rst_len_m1};
          count_inc  = 1'b1;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      ST_RESET: begin
        if (cnt == 16'd0) state_next = ST_HOLDOFF;
        else              cnt_next   = cnt - 16'd1;
      end
      ST_HOLDOFF: begin
        if (!wdt_expired) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= 16'd0;
      wdt_prev      <= 1'b0;
      irq           <= 1'b0;
      sys_reset_out <= 1'b0;
      state_out     <= 2'd0;
      enable        <= 1'b0;
      grace         <= GRACE_RST;
      rst_len       <= RSTLEN_RST;
      reset_count   <= 8'd0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      wdt_prev      <= wdt_expired;
      irq           <= (state_next == ST_WARN);
      sys_reset_out <= (state_next == ST_RESET);
      state_out     <= state_next;

      if (wr_ctrl) enable <= bus.data_in[0];

      // Timing config is frozen while an escalation is in flight.
      if (wr_grace && state == ST_IDLE) begin
        if (bus.data_write_n == 2'b00) grace[7:0] <= bus.data_in[7:0];
        else                           grace      <= bus.data_in[15:0];
      end
      if (wr_rst_len && state == ST_IDLE) rst_len <= bus.data_in[7:0];

      if (wr_status)                               reset_count <= 8'd0;
      else if (count_inc && reset_count != 8'hFF)  reset_count <= reset_count + 8'd1;
    end
  end

  always_comb begin
    bus.data_out = 32'h0;
    case (bus.address)
      6'h0:    bus.data_out = {31'h0, enable};
      6'h2:    bus.data_out = {16'h0, grace};
      6'h3:    bus.data_out = {24'h0, rst_len};
      6'h4:    bus.data_out = {16'h0, reset_count, 5'h0, irq, state};
      default: bus.data_out = 32'h0;
    endcase
  end

  assign bus.data_ready = 1'b1;

  logic unused_bus;
  assign unused_bus = &{1'b0, bus.data_read_n, bus.data_in[31:16]};

endmodule

// File: tb/tb_tqvp_stevej_wdt_escalator.sv
// Directed scoreboard bench for the watchdog escalator.
module tb_tqvp_stevej_wdt_escalator;
  localparam logic [1:0] W8 = 2'b00, W16 = 2'b01, W32 = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wdt_expired = 1'b0;
  logic       irq, sys_reset_out;
  logic [1:0] state_out;

  tqvp_stevej_wdt_escalator_if bus();

  tqvp_stevej_wdt_escalator dut (
    .clk           (clk),
    .rst           (rst),
    .wdt_expired   (wdt_expired),
    .bus           (bus),
    .irq           (irq),
    .sys_reset_out (sys_reset_out),
    .state_out     (state_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // kind: 0 state_out, 1 irq, 2 sys_reset_out, 3 data_out, 4 data_ready
  function automatic void sb_push(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    q.push_back(e);
  endfunction

  function automatic void chk_st(input logic [1:0] st, input string nm);
    sb_push(0, {30'h0, st}, {nm, "_state"});
    sb_push(1, {31'h0, st == 2'd1}, {nm, "_irq"});
    sb_push(2, {31'h0, st == 2'd2}, {nm, "_sysrst"});
  endfunction

  function automatic void rd(input logic [5:0] a, input logic [31:0] v, input string nm);
    bus.address = a;
    sb_push(3, v, nm);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    bus.address      = a;
    bus.data_in      = d;
    bus.data_write_n = sz;
    step();
    bus.data_write_n = 2'b11;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] obs;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        0:       obs = {30'h0, state_out};
        1:       obs = {31'h0, irq};
        2:       obs = {31'h0, sys_reset_out};
        3:       obs = bus.data_out;
        default: obs = {31'h0, bus.data_ready};
      endcase
      n_cmp++;
      if (e.cyc != cyc || obs !== e.val) begin
        n_bad++;
        $display("FAIL %s: cycle %0d (queued %0d) got 0x%0h expected 0x%0h",
                 e.name, cyc, e.cyc, obs, e.val);
      end
    end
  end

  initial begin
    bus.address      = 6'h0;
    bus.data_in      = 32'h0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    step();
    step();

    // reset values
    chk_st(2'd0, "rst");
    sb_push(4, 32'h1, "data_ready");
    rd(6'h2, 32'd1000, "rst_grace"); step();
    rd(6'h3, 32'd16, "rst_rstlen"); step();
    rd(6'h0, 32'h0, "rst_ctrl"); step();
    rd(6'h4, 32'h0, "rst_status"); rd(6'h4, 32'h0, "rst_status"); step();
    rst = 1'b0;

    // full escalation, GRACE=5, RST_LEN=16
    bus_wr(6'h0, 32'h1, W32);
    bus_wr(6'h2, 32'd5, W32);
    rd(6'h2, 32'd5, "grace_wr"); step();
    wdt_expired = 1'b1;
    chk_st(2'd0, "t1_pre_rise"); step();
    repeat (6)  begin chk_st(2'd1, "t1_warn");  step(); end
    repeat (16) begin chk_st(2'd2, "t1_reset"); step(); end
    chk_st(2'd3, "t1_holdoff");
    rd(6'h4, 32'h0000_0103, "t1_status"); step();
    wdt_expired = 1'b0;
    chk_st(2'd3, "t1_hold_last"); step();
    chk_st(2'd0, "t1_idle"); step();

    // valid ACK on third WARN cycle
    bus_wr(6'h4, 32'h0, W32);
    wdt_expired = 1'b1; step();
    chk_st(2'd1, "t2_w1"); step();
    chk_st(2'd1, "t2_w2"); step();
    chk_st(2'd1, "t2_w3"); bus_wr(6'h1, 32'hA5, W8);
    repeat (8) begin chk_st(2'd0, "t2_acked"); step(); end
    rd(6'h4, 32'h0, "t2_status"); step();
    wdt_expired = 1'b0; step();

    // wrong ACK value does not stop escalation
    wdt_expired = 1'b1; step();
    chk_st(2'd1, "t2b_w1"); step();
    chk_st(2'd1, "t2b_w2"); step();
    chk_st(2'd1, "t2b_w3"); bus_wr(6'h1, 32'h5A, W8);
    repeat (3)  begin chk_st(2'd1, "t2b_warn");  step(); end
    repeat (16) begin chk_st(2'd2, "t2b_reset"); step(); end
    chk_st(2'd3, "t2b_holdoff");
    rd(6'h4, 32'h0000_0103, "t2b_status"); step();
    wdt_expired = 1'b0; step();

    // ACK exactly on the cnt==0 cycle, GRACE=3
    bus_wr(6'h2, 32'd3, W32);
    wdt_expired = 1'b1; step();
    repeat (3) begin chk_st(2'd1, "t3_warn"); step(); end
    chk_st(2'd1, "t3_cnt0"); bus_wr(6'h1, 32'hA5, W32);
    repeat (5) begin chk_st(2'd0, "t3_no_reset"); step(); end
    wdt_expired = 1'b0; step();

    // RST_LEN=0 gives one-cycle pulse; stuck expiry holds off
    bus_wr(6'h3, 32'd0, W32);
    wdt_expired = 1'b1; step();
    repeat (4) begin chk_st(2'd1, "t4_warn"); step(); end
    chk_st(2'd2, "t4_pulse"); step();
    repeat (3) begin chk_st(2'd3, "t4_stuck"); step(); end
    wdt_expired = 1'b0;
    chk_st(2'd3, "t4_hold_last"); step();
    chk_st(2'd0, "t4_idle");
    wdt_expired = 1'b1; step();
    chk_st(2'd1, "t4_retrigger"); bus_wr(6'h1, 32'hA5, W16);
    chk_st(2'd0, "t4_acked");
    wdt_expired = 1'b0; step();

    // saturation of reset_count with GRACE=0, RST_LEN=0
    bus_wr(6'h2, 32'd0, W32);
    bus_wr(6'h4, 32'h0, W32);
    repeat (255) begin
      wdt_expired = 1'b1; step(); step(); step();
      wdt_expired = 1'b0; step();
    end
    rd(6'h4, 32'h0000_FF00, "t5_count255"); step();
    wdt_expired = 1'b1; step(); step(); step();
    wdt_expired = 1'b0; step();
    rd(6'h4, 32'h0000_FF00, "t5_saturated"); step();

    // STATUS clear coinciding with RESET entry wins
    wdt_expired = 1'b1; step();
    chk_st(2'd1, "t5_warn"); bus_wr(6'h4, 32'h0, W8);
    chk_st(2'd2, "t5_reset");
    rd(6'h4, 32'h0000_0002, "t5_clear_wins"); step();
    wdt_expired = 1'b0; step();
    chk_st(2'd0, "t5_idle"); step();

    // GRACE write during WARN is ignored
    bus_wr(6'h2, 32'd2, W32);
    wdt_expired = 1'b1; step();
    chk_st(2'd1, "t5g_w1"); bus_wr(6'h2, 32'h55, W32);
    chk_st(2'd1, "t5g_w2"); rd(6'h2, 32'd2, "t5g_grace_locked"); step();
    chk_st(2'd1, "t5g_w3"); bus_wr(6'h1, 32'hA5, W32);
    chk_st(2'd0, "t5g_acked"); rd(6'h2, 32'd2, "t5g_grace_after"); step();
    wdt_expired = 1'b0; step();

    // reset asserted on fourth RESET cycle
    bus_wr(6'h2, 32'd0, W32);
    bus_wr(6'h3, 32'd16, W32);
    wdt_expired = 1'b1; step();
    chk_st(2'd1, "t6_warn"); step();
    repeat (3) begin chk_st(2'd2, "t6_reset"); step(); end
    chk_st(2'd2, "t6_r4");
    rst = 1'b1; step();
    chk_st(2'd0, "t6_after_rst");
    rd(6'h0, 32'h0, "t6_ctrl"); step();
    rd(6'h2, 32'd1000, "t6_grace"); step();
    rd(6'h3, 32'd16, "t6_rstlen"); step();
    rd(6'h4, 32'h0, "t6_status"); step();
    rst = 1'b0;
    wdt_expired = 1'b0;
    repeat (3) step();

    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
